// File: rtl/fp_pkg.sv
// fp_pkg: binary32 constants and squarer FSM state encoding shared across the block
package fp_pkg;
  localparam logic [7:0] FP32_BIAS = 8'd127;
  localparam logic [7:0] FP32_EXP_MAX = 8'd255;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] PINF = 32'h7F80_0000;
  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} fsq_state_e;
endpackage

// File: rtl/floating_square_seq_if.sv
// floating_square_seq_if: operand/result valid-ready handshake bundle for the squarer
interface floating_square_seq_if #(parameter int XLEN = 32);
  logic in_valid;
  logic in_ready;
  logic [XLEN-1:0] A;
  logic out_valid;
  logic out_ready;
  logic [XLEN-1:0] result;
  logic overflow;
  logic underflow;
  logic exception;
  logic busy;
  modport master(output in_valid, A, out_ready, input in_ready, out_valid, result, overflow, underflow, exception, busy);
  modport slave(input in_valid, A, out_ready, output in_ready, out_valid, result, overflow, underflow, exception, busy);
endinterface

// File: rtl/fp_mant_serial_mul.sv
// fp_mant_serial_mul: 24x24 serial shift-add multiplier, one multiplier bit per cycle LSB first
module fp_mant_serial_mul (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [23:0] m_i,
  output logic        done_o,
  output logic [47:0] prod_o
);
  logic [23:0] m_q;
  logic [4:0] cnt_q;
  logic run_q;
  logic [47:0] acc_q;
  // load operand on start, then add (m << i) for each set bit i over 24 cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
      acc_q <= '0;
    end else if (start_i) begin
      m_q <= m_i;
      cnt_q <= '0;
      run_q <= 1'b1;
      acc_q <= '0;
    end else if (run_q) begin
      acc_q <= acc_q + (m_q[cnt_q] ? {24'b0, m_q} << cnt_q : 48'b0);
      cnt_q <= cnt_q + 5'd1;
      run_q <= cnt_q != 5'd23;
    end
  end
  assign done_o = run_q && cnt_q == 5'd23;
  assign prod_o = acc_q;
endmodule

// File: rtl/floating_square_seq.sv
// floating_square_seq: multi-cycle binary32 squarer; FSQ_RNE_EN selects round-to-nearest-even, else truncation
module floating_square_seq
  import fp_pkg::*;
(
  input logic clk,
  input logic rst,
  floating_square_seq_if.slave io
);
`ifdef FSQ_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif
  fsq_state_e state_q, state_d;
  logic [7:0] exp_q, exp_d;
  logic [31:0] result_q, result_d, norm_res;
  logic ovf_q, ovf_d, unf_q, unf_d, exc_q, exc_d;
  logic accept, e_max, special, start, done, n, g, s, rnd_up, carry, ovf_n, unf_n;
  logic [47:0] p;
  logic [22:0] frac;
  logic [23:0] rnd;
  logic signed [9:0] e, e_f;
  assign accept = io.in_valid && io.in_ready;
  assign e_max = io.A[30:23] == FP32_EXP_MAX;
  assign special = io.A[30:23] == 8'd0 || e_max;
  assign start = accept && !special;
  fp_mant_serial_mul u_mul (
    .clk(clk),
    .rst(rst),
    .start_i(start),
    .m_i({1'b1, io.A[22:0]}),
    .done_o(done),
    .prod_o(p)
  );
  assign n = p[47];
  assign frac = n ? p[46:24] : p[45:23];
  assign g = n ? p[23] : p[22];
  assign s = n ? |p[22:0] : |p[21:0];
  assign rnd_up = RNE && g && (s || frac[0]);
  assign rnd = {1'b0, frac} + {23'b0, rnd_up};
  assign carry = rnd[23];
  assign e = $signed({1'b0, exp_q, 1'b0}) - $signed({2'b0, FP32_BIAS}) + $signed({9'b0, n});
  assign e_f = e + $signed({9'b0, carry});
  assign ovf_n = e_f >= $signed({2'b0, FP32_EXP_MAX});
  assign unf_n = e_f <= 10'sd0;
  assign norm_res = ovf_n ? PINF : unf_n ? 32'h0 : {1'b0, e_f[7:0], rnd[22:0]};
  // state and result/flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      exp_q <= '0;
      result_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      exc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q <= exp_d;
      result_q <= result_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      exc_q <= exc_d;
    end
  end
  // next state: specials finish on accept, normals multiply then round/pack in NORM
  always_comb begin
    state_d = state_q;
    exp_d = exp_q;
    result_d = result_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    exc_d = exc_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = special ? DONE : MUL;
        exp_d = io.A[30:23];
        result_d = e_max ? (|io.A[22:0] ? QNAN : PINF) : 32'h0;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        exc_d = e_max;
      end
      MUL: state_d = done ? NORM : MUL;
      NORM: begin
        state_d = DONE;
        result_d = norm_res;
        ovf_d = ovf_n;
        unf_d = !ovf_n && unf_n;
      end
      DONE: state_d = io.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  assign io.in_ready = state_q == IDLE;
  assign io.busy = state_q != IDLE;
  assign io.out_valid = state_q == DONE;
  assign io.result = result_q;
  assign io.overflow = ovf_q;
  assign io.underflow = unf_q;
  assign io.exception = exc_q;
endmodule

// File: tb/tb_floating_square_seq.sv
// tb_floating_square_seq: directed and randomized checks of the serial squarer against an arithmetic model
module tb_floating_square_seq;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] PINF = 32'h7F80_0000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  floating_square_seq_if io();
  floating_square_seq dut(.clk(clk), .rst(rst), .io(io));
  always #5 clk = ~clk;

  // returns {result, overflow, underflow, exception}
  function automatic logic [34:0] ref_sq(input logic [31:0] a);
    longint unsigned m, p, q;
    int e8, sh, ex, n;
`ifdef FSQ_RNE_EN
    longint unsigned rem, half;
`endif
    e8 = int'(a[30:23]);
    if (e8 == 0) return {32'h0, 3'b000};
    if (e8 == 255) return {(a[22:0] != 0) ? QNAN : PINF, 3'b001};
    m = 64'h80_0000 | 64'(a[22:0]);
    p = m * m;
    n = (p >> 47) != 0 ? 1 : 0;
    sh = 23 + n;
    q = p >> sh;
`ifdef FSQ_RNE_EN
    rem = p - (q << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 1;
`endif
    ex = 2 * e8 - 127 + n;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      ex++;
    end
    if (ex >= 255) return {PINF, 3'b100};
    if (ex <= 0) return {32'h0, 3'b010};
    return {1'b0, 8'(ex), 23'(q), 3'b000};
  endfunction

  task automatic do_op(input logic [31:0] a, output logic [31:0] r, output logic [2:0] f, output int lat);
    io.A = a;
    io.in_valid = 1'b1;
    @(posedge clk);
    #1 io.in_valid = 1'b0;
    lat = 1;
    while (io.out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    if (lat >= 100) begin
      checks++;
      failures++;
      $display("FAIL timeout a=%h out_valid never rose", a);
    end
    r = io.result;
    f = {io.overflow, io.underflow, io.exception};
  endtask

  task automatic release_out();
    io.out_ready = 1'b1;
    @(posedge clk);
    #1 io.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (io.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", io.out_valid); end
    checks++; if (io.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", io.in_ready); end
    checks++; if (io.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", io.busy); end
    checks++; if ({io.result, io.overflow, io.underflow, io.exception} !== 35'h0) begin failures++; $display("FAIL reset_outputs got=%h/%b%b%b exp=0", io.result, io.overflow, io.underflow, io.exception); end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] r; logic [2:0] f; int lat;
    do_op(32'h4040_0000, r, f, lat);
    checks++; if (r !== 32'h4110_0000) begin failures++; $display("FAIL basic_result got=%h exp=41100000", r); end
    checks++; if (f !== 3'b000) begin failures++; $display("FAIL basic_flags got=%b exp=000", f); end
    checks++; if (lat !== 26) begin failures++; $display("FAIL basic_latency got=%0d exp=26", lat); end
    release_out();
  endtask

  task automatic test_hold();
    logic [31:0] r; logic [2:0] f; int lat;
    do_op(32'hC000_0000, r, f, lat);
    checks++; if (r !== 32'h4080_0000) begin failures++; $display("FAIL hold_result got=%h exp=40800000", r); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++; if ({io.out_valid, io.in_ready, io.result} !== {2'b10, 32'h4080_0000}) begin failures++; $display("FAIL hold_stable cyc=%0d got=%b%b/%h exp=10/40800000", i, io.out_valid, io.in_ready, io.result); end
    end
    release_out();
    checks++; if ({io.out_valid, io.in_ready, io.busy} !== 3'b010) begin failures++; $display("FAIL hold_release got=%b%b%b exp=010", io.out_valid, io.in_ready, io.busy); end
  endtask

  task automatic test_rounding();
    logic [31:0] r, exp_r; logic [2:0] f; int lat;
`ifdef FSQ_RNE_EN
    exp_r = 32'h4010_0002;
`else
    exp_r = 32'h4010_0001;
`endif
    do_op(32'h3FC0_0001, r, f, lat);
    checks++; if (r !== exp_r) begin failures++; $display("FAIL rounding_result got=%h exp=%h", r, exp_r); end
    release_out();
  endtask

  task automatic test_ovf_unf();
    logic [31:0] r; logic [2:0] f; int lat;
    do_op(32'h60AD_78EC, r, f, lat);
    checks++; if ({r, f} !== {PINF, 3'b100}) begin failures++; $display("FAIL overflow got=%h/%b exp=7f800000/100", r, f); end
    release_out();
    do_op(32'h1E3C_E508, r, f, lat);
    checks++; if ({r, f} !== {32'h0, 3'b010}) begin failures++; $display("FAIL underflow got=%h/%b exp=00000000/010", r, f); end
    release_out();
  endtask

  task automatic test_special();
    logic [31:0] r; logic [2:0] f; int lat;
    do_op(32'h7FC0_0000, r, f, lat);
    checks++; if ({r, f, lat} !== {QNAN, 3'b001, 32'd1}) begin failures++; $display("FAIL special_nan got=%h/%b lat=%0d exp=7fc00000/001 lat=1", r, f, lat); end
    release_out();
    do_op(32'hFF80_0000, r, f, lat);
    checks++; if ({r, f, lat} !== {PINF, 3'b001, 32'd1}) begin failures++; $display("FAIL special_inf got=%h/%b lat=%0d exp=7f800000/001 lat=1", r, f, lat); end
    release_out();
    do_op(32'h0000_0001, r, f, lat);
    checks++; if ({r, f, lat} !== {32'h0, 3'b000, 32'd1}) begin failures++; $display("FAIL special_denorm got=%h/%b lat=%0d exp=00000000/000 lat=1", r, f, lat); end
    release_out();
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; logic [2:0] f; int lat; bit seen = 0;
    io.A = 32'h3FC0_0000;
    io.in_valid = 1'b1;
    @(posedge clk);
    #1 io.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++; if ({io.in_ready, io.busy, io.out_valid} !== 3'b100) begin failures++; $display("FAIL midreset_state got=%b%b%b exp=100", io.in_ready, io.busy, io.out_valid); end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1 if (io.out_valid === 1'b1) seen = 1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midreset_no_output got=%b exp=0", seen); end
    do_op(32'h3FC0_0000, r, f, lat);
    checks++; if ({r, f} !== {32'h4010_0000, 3'b000}) begin failures++; $display("FAIL midreset_next got=%h/%b exp=40100000/000", r, f); end
    release_out();
  endtask

  task automatic test_random();
    logic [31:0] a, r; logic [2:0] f; logic [34:0] m; int lat, exp_lat; logic [7:0] ex;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0: ex = 8'd0;
        1: ex = 8'd255;
        2: ex = 8'($urandom_range(188, 254));
        3: ex = 8'($urandom_range(50, 66));
        default: ex = 8'($urandom_range(67, 187));
      endcase
      a = {1'($urandom), ex, 23'($urandom)};
      m = ref_sq(a);
      exp_lat = (ex == 8'd0 || ex == 8'd255) ? 1 : 26;
      do_op(a, r, f, lat);
      checks++; if ({r, f} !== m) begin failures++; $display("FAIL random_value a=%h got=%h/%b exp=%h/%b", a, r, f, m[34:3], m[2:0]); end
      checks++; if (lat !== exp_lat) begin failures++; $display("FAIL random_latency a=%h got=%0d exp=%0d", a, lat, exp_lat); end
      release_out();
    end
  endtask

  initial begin
    io.in_valid = 1'b0;
    io.out_ready = 1'b0;
    io.A = '0;
    test_reset();
    test_basic();
    test_hold();
    test_rounding();
    test_ovf_unf();
    test_special();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
